reg_bank4_onehot: RTL

- 4-entry register bank sitting directly downstream of the 2-to-4 write-address decoder.
- Consumes the decoder's one-hot strobes (out3..out0) as write selects.
- Adds a valid/ready write channel, per-entry valid bits, two registered read ports, one-hot integrity checking and a sequenced clear-all engine.
- Forms the storage core of the register-file datapath.

---
 rtl/reg_bank_pkg.sv | 18 +
 rtl/onehot_check.sv | 24 ++
 rtl/reg_bank4_onehot.sv | 129 ++++++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared sizes, FSM states and select classes for the 4-entry register bank
package reg_bank_pkg;

  localparam int N_ENTRIES = 4;
  localparam int ADDR_W    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_MULTI = 2'd2
  } sel_class_e;

endpackage

// File: rtl/onehot_check.sv
// rtl/onehot_check.sv - classifies a decoder strobe vector as none / one-hot / multi-hot with index
module onehot_check
  import reg_bank_pkg::*;
(
  input  logic [N_ENTRIES-1:0] sel_i,
  output sel_class_e           class_o,
  output logic [ADDR_W-1:0]    idx_o
);

  // Exact-match table: anything that is neither zero nor a single bit is multi-hot.
  always_comb begin
    class_o = SEL_MULTI;
    idx_o   = '0;
    case (sel_i)
      4'b0000: class_o = SEL_NONE;
      4'b0001: begin class_o = SEL_ONE; idx_o = 2'd0; end
      4'b0010: begin class_o = SEL_ONE; idx_o = 2'd1; end
      4'b0100: begin class_o = SEL_ONE; idx_o = 2'd2; end
      4'b1000: begin class_o = SEL_ONE; idx_o = 2'd3; end
      default: class_o = SEL_MULTI;
    endcase
  end

endmodule

// File: rtl/reg_bank4_onehot.sv
// rtl/reg_bank4_onehot.sv - 4-entry register bank with one-hot write selects and clear sweep; REG_BANK_BYPASS_EN enables write-through reads
module reg_bank4_onehot
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [N_ENTRIES-1:0] wr_sel,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 clear_req,
  input  logic [ADDR_W-1:0]    rd_addr0,
  output logic [DATA_W-1:0]    rd_data0,
  input  logic [ADDR_W-1:0]    rd_addr1,
  output logic [DATA_W-1:0]    rd_data1,
  output logic [N_ENTRIES-1:0] entry_valid,
  output logic                 sel_err,
  output logic                 busy
);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]     entry_q [N_ENTRIES];
  logic [N_ENTRIES-1:0]  valid_q;
  logic                  sel_err_q;
  logic [DATA_W-1:0]     rd_data0_q, rd_data1_q;
  logic [DATA_W-1:0]     rd_data0_d, rd_data1_d;

  sel_class_e            sel_class;
  logic [ADDR_W-1:0]     wr_idx;
  logic                  wr_acc;
  logic                  wr_one;

  onehot_check u_onehot_check (
    .sel_i   (wr_sel),
    .class_o (sel_class),
    .idx_o   (wr_idx)
  );

  assign wr_acc = wr_valid & wr_ready;
  assign wr_one = wr_acc && (sel_class == SEL_ONE);

  // State and sweep index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: a clear request in IDLE starts a 4-cycle sweep; requests during the sweep are ignored.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (clear_req) state_d = CLEAR;
      end
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == ADDR_W'(N_ENTRIES - 1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Handshake and status outputs decode directly from the current state.
  always_comb begin
    wr_ready = 1'b1;
    busy     = 1'b0;
    case (state_q)
      IDLE:    begin wr_ready = 1'b1; busy = 1'b0; end
      CLEAR:   begin wr_ready = 1'b0; busy = 1'b1; end
      default: begin wr_ready = 1'b1; busy = 1'b0; end
    endcase
  end

  // Storage: the sweep zeroes one entry per cycle; writes only land in IDLE since wr_ready is low otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) entry_q[i] <= '0;
      valid_q <= '0;
    end else if (state_q == CLEAR) begin
      entry_q[idx_q] <= '0;
      valid_q[idx_q] <= 1'b0;
    end else if (wr_one) begin
      entry_q[wr_idx] <= wr_data;
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Read muxes; optional forwarding of a one-hot write aimed at the same entry.
  always_comb begin
    rd_data0_d = entry_q[rd_addr0];
    rd_data1_d = entry_q[rd_addr1];
`ifdef REG_BANK_BYPASS_EN
    if (wr_one && (wr_idx == rd_addr0)) rd_data0_d = wr_data;
    if (wr_one && (wr_idx == rd_addr1)) rd_data1_d = wr_data;
`endif
  end

  // Registered read ports and the one-cycle multi-hot error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data0_q <= '0;
      rd_data1_q <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      rd_data0_q <= rd_data0_d;
      rd_data1_q <= rd_data1_d;
      sel_err_q  <= wr_acc && (sel_class == SEL_MULTI);
    end
  end

  assign rd_data0    = rd_data0_q;
  assign rd_data1    = rd_data1_q;
  assign entry_valid = valid_q;
  assign sel_err     = sel_err_q;

endmodule
